// File: rtl/multi_freq_mixer.sv
// Complex frequency-shift mixer: rotates each IQ sample by (cos, sin) through a
// 4-stage pipeline with rounding, saturation and a sticky saturation counter.
module multi_freq_mixer #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int CNTW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_clr_cnt,
    input  logic                   i_data_vld,
    input  logic                   i_data_ca,
    input  logic signed [DW-1:0]   i_data_i,
    input  logic signed [DW-1:0]   i_data_q,
    input  logic signed [CW-1:0]   i_sin_coff,
    input  logic signed [CW-1:0]   i_cos_coff,
    output logic                   o_data_vld,
    output logic                   o_data_ca,
    output logic signed [DW-1:0]   o_data_i,
    output logic signed [DW-1:0]   o_data_q,
    output logic [CNTW-1:0]        o_sat_cnt,
    output logic                   o_sat_flag
);

    localparam int PW = DW + CW;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] RND     = {{(SW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // S1
    logic                 s1_vld_q, s1_ca_q, s1_en_q;
    logic signed [DW-1:0] s1_i_q, s1_q_q;
    logic signed [CW-1:0] s1_sin_q, s1_cos_q;
    // S2
    logic                 s2_vld_q, s2_ca_q, s2_en_q;
    logic signed [DW-1:0] s2_i_q, s2_q_q;
    logic signed [PW-1:0] s2_ic_q, s2_qs_q, s2_is_q, s2_qc_q;
    // S3
    logic                 s3_vld_q, s3_ca_q, s3_en_q;
    logic signed [DW-1:0] s3_i_q, s3_q_q;
    logic signed [SW-1:0] s3_sum_i_q, s3_sum_q_q;
    logic signed [SW-1:0] s3_sum_i_d, s3_sum_q_d;
    // S4 / accounting
    logic                 o_vld_q, o_ca_q, o_flag_q;
    logic signed [DW-1:0] o_i_q, o_q_q;
    logic [CNTW-1:0]      o_cnt_q;
    logic                 o_vld_d, o_ca_d, o_flag_d;
    logic signed [DW-1:0] o_i_d, o_q_d;
    logic [CNTW-1:0]      o_cnt_d;

    logic signed [SW-1:0] shr_i, shr_q;
    logic signed [DW-1:0] res_i, res_q;
    logic                 sat_i, sat_q, sat_evt;

    // Sums are one bit wider than products so cos=sin=-2^(CW-1) cannot overflow.
    always_comb begin
        s3_sum_i_d = {s2_ic_q[PW-1], s2_ic_q} - {s2_qs_q[PW-1], s2_qs_q} + RND;
        s3_sum_q_d = {s2_is_q[PW-1], s2_is_q} + {s2_qc_q[PW-1], s2_qc_q} + RND;
    end

    always_comb begin
        shr_i = s3_sum_i_q >>> (CW-1);
        shr_q = s3_sum_q_q >>> (CW-1);
        sat_i = 1'b0;
        sat_q = 1'b0;
        res_i = shr_i[DW-1:0];
        res_q = shr_q[DW-1:0];
        if (shr_i > SAT_MAX) begin
            res_i = SAT_MAX[DW-1:0];
            sat_i = 1'b1;
        end else if (shr_i < SAT_MIN) begin
            res_i = SAT_MIN[DW-1:0];
            sat_i = 1'b1;
        end
        if (shr_q > SAT_MAX) begin
            res_q = SAT_MAX[DW-1:0];
            sat_q = 1'b1;
        end else if (shr_q < SAT_MIN) begin
            res_q = SAT_MIN[DW-1:0];
            sat_q = 1'b1;
        end
    end

    always_comb begin
        o_vld_d  = s3_vld_q;
        o_ca_d   = s3_vld_q & s3_ca_q;
        o_i_d    = '0;
        o_q_d    = '0;
        sat_evt  = s3_vld_q & s3_en_q & (sat_i | sat_q);
        if (s3_vld_q) begin
            o_i_d = s3_en_q ? res_i : s3_i_q;
            o_q_d = s3_en_q ? res_q : s3_q_q;
        end
        o_cnt_d  = o_cnt_q;
        o_flag_d = o_flag_q | sat_evt;
        // Clear wins over an increment landing on the same edge.
        if (i_clr_cnt) begin
            o_cnt_d  = '0;
            o_flag_d = 1'b0;
        end else if (sat_evt && (o_cnt_q != {CNTW{1'b1}})) begin
            o_cnt_d = o_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_vld_q   <= 1'b0;
            s1_ca_q    <= 1'b0;
            s1_en_q    <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            s1_sin_q   <= '0;
            s1_cos_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_ca_q    <= 1'b0;
            s2_en_q    <= 1'b0;
            s2_i_q     <= '0;
            s2_q_q     <= '0;
            s2_ic_q    <= '0;
            s2_qs_q    <= '0;
            s2_is_q    <= '0;
            s2_qc_q    <= '0;
            s3_vld_q   <= 1'b0;
            s3_ca_q    <= 1'b0;
            s3_en_q    <= 1'b0;
            s3_i_q     <= '0;
            s3_q_q     <= '0;
            s3_sum_i_q <= '0;
            s3_sum_q_q <= '0;
            o_vld_q    <= 1'b0;
            o_ca_q     <= 1'b0;
            o_i_q      <= '0;
            o_q_q      <= '0;
            o_cnt_q    <= '0;
            o_flag_q   <= 1'b0;
        end else begin
            s1_vld_q   <= i_data_vld;
            s1_ca_q    <= i_data_ca;
            s1_en_q    <= i_en;
            s1_i_q     <= i_data_i;
            s1_q_q     <= i_data_q;
            s1_sin_q   <= i_sin_coff;
            s1_cos_q   <= i_cos_coff;

            s2_vld_q   <= s1_vld_q;
            s2_ca_q    <= s1_ca_q;
            s2_en_q    <= s1_en_q;
            s2_i_q     <= s1_i_q;
            s2_q_q     <= s1_q_q;
            s2_ic_q    <= s1_i_q * s1_cos_q;
            s2_qs_q    <= s1_q_q * s1_sin_q;
            s2_is_q    <= s1_i_q * s1_sin_q;
            s2_qc_q    <= s1_q_q * s1_cos_q;

            s3_vld_q   <= s2_vld_q;
            s3_ca_q    <= s2_ca_q;
            s3_en_q    <= s2_en_q;
            s3_i_q     <= s2_i_q;
            s3_q_q     <= s2_q_q;
            s3_sum_i_q <= s3_sum_i_d;
            s3_sum_q_q <= s3_sum_q_d;

            o_vld_q    <= o_vld_d;
            o_ca_q     <= o_ca_d;
            o_i_q      <= o_i_d;
            o_q_q      <= o_q_d;
            o_cnt_q    <= o_cnt_d;
            o_flag_q   <= o_flag_d;
        end
    end

    assign o_data_vld = o_vld_q;
    assign o_data_ca  = o_ca_q;
    assign o_data_i   = o_i_q;
    assign o_data_q   = o_q_q;
    assign o_sat_cnt  = o_cnt_q;
    assign o_sat_flag = o_flag_q;

endmodule
